// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and write-request type for the register file write path
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wrq_fwd.sv
// rtl/regfile_wrq_fwd.sv - youngest-match forwarding search over pending write entries
module regfile_wrq_fwd
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic [ADDR_W-1:0]      addr_mem [DEPTH],
  input  logic [DATA_W-1:0]      data_mem [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  input  logic [$clog2(DEPTH):0] count,
  input  logic [ADDR_W-1:0]      lk_addr,
  output logic                   lk_hit,
  output logic [DATA_W-1:0]      lk_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (addr_mem[rd_ptr + PW'(i)] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_mem[rd_ptr + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/regfile_wr_queue.sv
// rtl/regfile_wr_queue.sv - in-order write-request buffer in front of the register file write port
module regfile_wr_queue
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic                   rf_wr_ready,
  input  logic [ADDR_W-1:0]      lk_addr,
  output logic                   lk_hit,
  output logic [DATA_W-1:0]      lk_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;
  logic              push;
  logic              pop;

  // Occupancy seen by the outputs reads as empty while reset is held.
  assign occ      = rst ? '0 : count;
  assign in_ready = (occ != CW'(DEPTH));
  assign rf_we    = (occ != '0);
  assign push     = in_valid && in_ready && !rst;
  assign pop      = rf_we && rf_wr_ready;

  assign rf_waddr = addr_mem[rd_ptr];
  assign rf_wdata = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  regfile_wrq_fwd #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fwd (
    .addr_mem (addr_mem),
    .data_mem (data_mem),
    .rd_ptr   (rd_ptr),
    .count    (occ),
    .lk_addr  (lk_addr),
    .lk_hit   (lk_hit),
    .lk_data  (lk_data)
  );

endmodule

// File: tb/tb_regfile_wr_queue.sv
// tb/tb_regfile_wr_queue.sv - scoreboard bench for regfile_wr_queue
module tb_regfile_wr_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wr_ready = 1'b0;
  logic [4:0]  lk_addr = '0;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;
  wr_req_t exp_q[$];

  regfile_wr_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wr_ready(rf_wr_ready), .lk_addr(lk_addr),
    .lk_hit(lk_hit), .lk_data(lk_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_addr) && $stable(in_data)))
  else begin
    errors++;
    $display("FAIL protocol: request changed while stalled at %0t", $time);
  end

  // Monitor: reference is the ordered list of accepted-but-uncommitted requests.
  always @(negedge clk) begin
    wr_req_t e;
    logic        m_hit;
    logic [31:0] m_data;
    if (rst) begin
      chk("rst_rf_we", rf_we, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_lk_hit", lk_hit, 0);
      chk("rst_lk_data", lk_data, 0);
    end else begin
      chk("count", count, exp_q.size());
      chk("in_ready", in_ready, exp_q.size() != DEPTH);
      chk("rf_we", rf_we, exp_q.size() != 0);
      m_hit  = 1'b0;
      m_data = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i].addr == lk_addr) begin
          m_hit  = 1'b1;
          m_data = exp_q[i].data;
        end
      end
      chk("lk_hit", lk_hit, m_hit);
      chk("lk_data", lk_data, m_data);
      if (rf_we && rf_wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rf_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rf_waddr", rf_waddr, e.addr);
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  task automatic rand_drive();
    if (rand_mode) begin
      rf_wr_ready = ($urandom_range(0, 2) != 0);
      lk_addr     = 5'($urandom_range(0, 7));
    end
  endtask

  // Called at posedge+1; returns with inputs updated at posedge+1.
  task automatic push_one(input logic [4:0] a, input logic [31:0] d, output int waits);
    bit hs;
    wr_req_t r;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    waits    = 0;
    hs       = 1'b0;
    while (!hs && waits < 50) begin
      @(negedge clk);
      hs = in_ready && !rst;
      @(posedge clk);
      if (hs) begin
        r.addr = a;
        r.data = d;
        exp_q.push_back(r);
      end else begin
        waits++;
      end
      #1;
      if (!hs) rand_drive();
    end
    if (!hs) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
    rand_drive();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rand_drive();
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    rf_wr_ready = 1'b1;
    while (exp_q.size() != 0 && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_rf_we", rf_we, 0);
    chk("idle_count", count, 0);
    chk("idle_lk_hit", lk_hit, 0);
    @(posedge clk);
    #1;

    // Single write
    rf_wr_ready = 1'b1;
    push_one(5'd3, 32'hDEAD_BEEF, w);
    @(negedge clk);
    chk("single_rf_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 3);
    chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_after_count", count, 0);
    chk("single_after_rf_we", rf_we, 0);
    @(posedge clk);
    #1;

    // Fill and stall, then drain with a fifth request waiting
    rf_wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(5'(i), 32'h100 + i, w);
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rf_wr_ready = 1'b1;
    push_one(5'd5, 32'h105, w);
    chk("fifth_waits", w, 1);
    drain();

    // Forwarding picks the youngest duplicate
    rf_wr_ready = 1'b0;
    push_one(5'd7, 32'h11, w);
    push_one(5'd7, 32'h22, w);
    lk_addr = 5'd7;
    @(negedge clk);
    chk("fwd_hit", lk_hit, 1);
    chk("fwd_data", lk_data, 32'h22);
    @(posedge clk);
    #1;
    lk_addr = 5'd8;
    @(negedge clk);
    chk("fwd_miss_hit", lk_hit, 0);
    chk("fwd_miss_data", lk_data, 0);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back push/pop across pointer wrap
    rf_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_one(5'($urandom_range(0, 31)), $urandom, w);
    @(negedge clk);
    chk("wrap_count", count, 1);
    @(posedge clk);
    #1;
    drain();

    // Reset with entries pending
    rf_wr_ready = 1'b0;
    push_one(5'd9, 32'hA9, w);
    push_one(5'd10, 32'hAA, w);
    push_one(5'd11, 32'hAB, w);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b0;
    lk_addr = 5'd10;
    @(negedge clk);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_rf_we", rf_we, 0);
    chk("rst_mid_lk_hit", lk_hit, 0);
    @(posedge clk);
    #1;

    // Randomized traffic
    rand_mode = 1'b1;
    rand_drive();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) push_one(5'($urandom_range(0, 7)), $urandom, w);
      else idle(1);
    end
    rand_mode = 1'b0;
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
